icn_sendq: RTL and testbench
============================

ICN_SENDQ -- requirements
Module: icn_sendq

Interface
REQ-001 SHALL have parameters: N, 8, number of MVUs; W, 64, data word width; BADDR, 15, destination address width; DEPTH, 8, queue entries (power of two, >=2).
REQ-002 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have ports: clr  in  1  synchronous, active-low reset.
REQ-004 SHALL have ports: wr_en  in  1  enqueue request; wr_to  in  N  destination MVU selector bits; wr_addr  in  BADDR  destination memory address; wr_word  in  W  payload.
REQ-005 SHALL have ports: wr_full  out  1  queue full; ovf  out  1  sticky overflow flag; flush  in  1  discard all queued and pending words.
REQ-006 SHALL have ports: send_to  out  N; send_en  out  1; send_addr  out  BADDR; send_word  out  W; these drive one MVU's slice of the interconnect send bus.
REQ-007 SHALL have ports: send_gnt  in  1  interconnect accepted the presented word this cycle.

Function
REQ-008 SHALL hold a FIFO of DEPTH entries, each {wr_to, wr_addr, wr_word}, with occupancy count 0..DEPTH.
REQ-009 SHALL enqueue on wr_en=1 when wr_full=0 and wr_to is nonzero; wr_en with wr_to=0 SHALL be silently dropped.
REQ-010 SHALL assert wr_full combinationally when count equals DEPTH; wr_en while full SHALL be dropped and SHALL set ovf, even if a pop occurs the same cycle.
REQ-011 SHALL implement FSM IDLE/SEND: IDLE drives send_en=0; SEND drives send_en=1 with send_to/send_addr/send_word registered from the FIFO head.
REQ-012 SHALL transition IDLE->SEND on the cycle after the FIFO becomes non-empty; word written at edge t appears on send_* with send_en=1 after edge t+1 (latency 1 cycle from enqueue edge).
REQ-013 SHALL hold send_* stable in SEND until send_gnt=1 is sampled; on that edge the word is popped.
REQ-014 SHALL, on a granted pop with further entries queued, load the next entry on the same edge and stay in SEND (back-to-back, one word per cycle at full throughput).
REQ-015 SHALL, on a granted pop leaving the FIFO empty, go to IDLE and clear send_en; a simultaneous enqueue SHALL cause SEND on the following edge.
REQ-016 SHALL ignore send_gnt while in IDLE.
REQ-017 SHALL, when flush=1, empty the FIFO, return to IDLE, clear send_en, and ignore wr_en that cycle; ovf is not affected.
REQ-018 SHALL wrap read and write pointers modulo DEPTH; simultaneous enqueue and pop leaves count unchanged.

Reset
REQ-019 SHALL, on clk edge with clr=0, set count=0, pointers=0, state IDLE, send_en=0, send_to=0, send_addr=0, send_word=0, ovf=0; clr overrides flush, wr_en and send_gnt.
REQ-020 SHALL discard any word in SEND when reset arrives mid-transfer; no word is re-presented after reset.

Configuration
REQ-021 SHALL, with ICN_SENDQ_CNT_EN defined, add output sent_cnt (32 bits) incrementing by one on every granted pop, wrapping at 2^32, reset to 0 by clr and not by flush.
REQ-022 SHALL, without ICN_SENDQ_CNT_EN, have no sent_cnt port and no counter logic.

Verification
REQ-023 Bench: N=4, enqueue one word {to=4'b0010, addr=0x10, word=0xAA} into empty queue, send_gnt tied 1 -> send_en high exactly one cycle, carrying those values, one cycle after enqueue edge.
REQ-024 Bench: enqueue 8 words with send_gnt=0 -> wr_full=1 after 8th; 9th write dropped, ovf=1; then send_gnt=1 -> 8 words emitted in order on 8 consecutive cycles, then IDLE.
REQ-025 Bench: enqueue with wr_to=0 -> nothing queued, send_en stays 0, ovf stays 0.
REQ-026 Bench: 3 words queued, send_gnt=0, assert flush -> send_en=0 next cycle, later send_gnt=1 yields no output.
REQ-027 Bench: clr=0 asserted while send_en=1 -> all outputs 0 next edge; with ICN_SENDQ_CNT_EN, sent_cnt=0 after reset and equals 5 after 5 granted words.

Source files
------------

// File: rtl/icn_sendq.sv
// icn_sendq: per-MVU send queue feeding one slice of the interconnect send bus.
// Optional feature: define ICN_SENDQ_CNT_EN to add the 32-bit sent_cnt output.
module icn_sendq #(
    parameter int N     = 8,
    parameter int W     = 64,
    parameter int BADDR = 15,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [N-1:0]     wr_to,
    input  logic [BADDR-1:0] wr_addr,
    input  logic [W-1:0]     wr_word,
    output logic             wr_full,
    output logic             ovf,
    input  logic             flush,
    output logic [N-1:0]     send_to,
    output logic             send_en,
    output logic [BADDR-1:0] send_addr,
    output logic [W-1:0]     send_word,
    input  logic             send_gnt
`ifdef ICN_SENDQ_CNT_EN
    ,
    output logic [31:0]      sent_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = N + BADDR + W;

    typedef enum logic {IDLE, SEND} state_t;

    state_t             r_state, w_state_nxt;
    logic [EW-1:0]      r_mem [DEPTH];
    logic [AW-1:0]      r_rptr, r_wptr, w_rd_idx;
    logic [AW:0]        r_count;
    logic               r_ovf;
    logic [N-1:0]       r_send_to;
    logic [BADDR-1:0]   r_send_addr;
    logic [W-1:0]       r_send_word;
    logic               w_push, w_pop, w_load, w_clear;

    assign wr_full   = (r_count == (AW+1)'(DEPTH));
    assign w_push    = wr_en && !wr_full && (|wr_to) && !flush;
    assign ovf       = r_ovf;
    assign send_en   = (r_state == SEND);
    assign send_to   = r_send_to;
    assign send_addr = r_send_addr;
    assign send_word = r_send_word;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!clr) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next state plus pop/load/clear decisions; the presented word stays in the FIFO until granted
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_clear     = 1'b0;
        w_rd_idx    = r_rptr;
        if (flush) begin
            w_state_nxt = IDLE;
            w_clear     = 1'b1;
        end else if (r_state == IDLE) begin
            if (r_count != '0) begin
                w_state_nxt = SEND;
                w_load      = 1'b1;
            end
        end else if (send_gnt) begin
            w_pop = 1'b1;
            if (r_count > (AW+1)'(1)) begin
                w_load   = 1'b1;
                w_rd_idx = r_rptr + AW'(1);
            end else begin
                w_state_nxt = IDLE;
                w_clear     = 1'b1;
            end
        end
    end

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (flush) begin
                r_rptr  <= '0;
                r_wptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + AW'(1);
                if (w_pop)  r_rptr <= r_rptr + AW'(1);
                r_count <= (w_push && !w_pop) ? r_count + (AW+1)'(1) :
                           (!w_push && w_pop) ? r_count - (AW+1)'(1) : r_count;
            end
            if (wr_en && wr_full && !flush) r_ovf <= 1'b1;
        end
    end

    // Entry storage; no reset needed since pointers gate every read
    always_ff @(posedge clk) begin
        if (clr && w_push) r_mem[r_wptr] <= {wr_to, wr_addr, wr_word};
    end

    // Presented word: loaded from the head, zeroed whenever the queue goes idle
    always_ff @(posedge clk) begin
        if (!clr || w_clear) begin
            r_send_to   <= '0;
            r_send_addr <= '0;
            r_send_word <= '0;
        end else if (w_load) begin
            {r_send_to, r_send_addr, r_send_word} <= r_mem[w_rd_idx];
        end
    end

`ifdef ICN_SENDQ_CNT_EN
    logic [31:0] r_sent_cnt;
    assign sent_cnt = r_sent_cnt;

    // Granted-word counter, cleared only by reset
    always_ff @(posedge clk) begin
        if (!clr)       r_sent_cnt <= '0;
        else if (w_pop) r_sent_cnt <= r_sent_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_icn_sendq.sv
// tb_icn_sendq: queue-model scoreboard plus directed literal checks for icn_sendq.
module tb_icn_sendq;
    localparam int N  = 4;
    localparam int W  = 64;
    localparam int BA = 15;
    localparam int D  = 8;

    logic          clk = 1'b0, clr = 1'b0, wr_en = 1'b0, flush = 1'b0, send_gnt = 1'b0;
    logic [N-1:0]  wr_to = '0;
    logic [BA-1:0] wr_addr = '0;
    logic [W-1:0]  wr_word = '0;
    logic          wr_full, ovf, send_en;
    logic [N-1:0]  send_to;
    logic [BA-1:0] send_addr;
    logic [W-1:0]  send_word;
`ifdef ICN_SENDQ_CNT_EN
    logic [31:0]   sent_cnt;
`endif

    icn_sendq #(.N(N), .W(W), .BADDR(BA), .DEPTH(D)) dut (
        .clk(clk), .clr(clr), .wr_en(wr_en), .wr_to(wr_to), .wr_addr(wr_addr),
        .wr_word(wr_word), .wr_full(wr_full), .ovf(ovf), .flush(flush),
        .send_to(send_to), .send_en(send_en), .send_addr(send_addr),
        .send_word(send_word), .send_gnt(send_gnt)
`ifdef ICN_SENDQ_CNT_EN
        , .sent_cnt(sent_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]  to;
        logic [BA-1:0] addr;
        logic [W-1:0]  word;
    } ent_t;

    ent_t        q[$];
    bit          m_en, m_ovf;
    int unsigned m_cnt;
    int          n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // What the queue must hold and present after one edge with the current inputs
    task automatic model_edge();
        int sz;
        bit g;
        sz = q.size();
        if (!clr) begin
            q.delete(); m_en = 0; m_ovf = 0; m_cnt = 0;
            return;
        end
        if (flush) begin
            q.delete(); m_en = 0;
            return;
        end
        if (wr_en && sz == D) m_ovf = 1;
        g = m_en && send_gnt;
        m_en = m_en ? (g ? (sz > 1) : 1'b1) : (sz > 0);
        if (g) begin
            void'(q.pop_front());
            m_cnt++;
        end
        if (wr_en && sz < D && wr_to != 0) q.push_back({wr_to, wr_addr, wr_word});
    endtask

    task automatic check_all();
        ent_t e;
        e = m_en ? q[0] : '0;
        chk("send_en", send_en, m_en);
        chk("send_to", send_to, e.to);
        chk("send_addr", send_addr, e.addr);
        chk("send_word", send_word, e.word);
        chk("wr_full", wr_full, q.size() == D);
        chk("ovf", ovf, m_ovf);
`ifdef ICN_SENDQ_CNT_EN
        chk("sent_cnt", sent_cnt, m_cnt);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic push(input logic [N-1:0] to, input logic [BA-1:0] a, input logic [W-1:0] w);
        wr_en = 1; wr_to = to; wr_addr = a; wr_word = w;
        step();
        wr_en = 0;
    endtask

    initial begin
        clr = 0;
        step(); step();
        chk("rst_en", send_en, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_full", wr_full, 0);
        chk("rst_word", send_word, 0);
        clr = 1;

        push(4'b0000, 15'h5, 64'h55);
        step();
        chk("to0_en", send_en, 0);
        chk("to0_ovf", ovf, 0);
        chk("to0_full", wr_full, 0);

        send_gnt = 1;
        push(4'b0010, 15'h10, 64'hAA);
        chk("one_lat0", send_en, 0);
        step();
        chk("one_en", send_en, 1);
        chk("one_to", send_to, 4'b0010);
        chk("one_addr", send_addr, 15'h10);
        chk("one_word", send_word, 64'hAA);
        step();
        chk("one_done", send_en, 0);

        send_gnt = 0;
        for (int i = 0; i < 8; i++) push(4'((i % 15) + 1), 15'(i), 64'hC0DE_0000 + 64'(i));
        chk("fill_full", wr_full, 1);
        chk("fill_ovf0", ovf, 0);
        push(4'b1000, 15'h7F, 64'hDEAD);
        chk("fill_ovf1", ovf, 1);
        chk("fill_full9", wr_full, 1);
        send_gnt = 1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_en", send_en, 1);
            chk("drain_word", send_word, 64'hC0DE_0000 + 64'(i));
            step();
        end
        chk("drain_idle", send_en, 0);
        chk("drain_full", wr_full, 0);

        send_gnt = 0;
        for (int i = 0; i < 3; i++) push(4'b0100, 15'(i), 64'(i + 100));
        chk("fl_pre_en", send_en, 1);
        flush = 1;
        step();
        flush = 0;
        chk("fl_en", send_en, 0);
        send_gnt = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl_quiet", send_en, 0);
        end
        chk("fl_ovf_kept", ovf, 1);

        clr = 0; step(); clr = 1;
        send_gnt = 1;
        for (int i = 0; i < 5; i++) push(4'b0001, 15'(i), 64'(i));
        for (int i = 0; i < 4; i++) step();
`ifdef ICN_SENDQ_CNT_EN
        chk("cnt5", sent_cnt, 5);
`endif
        send_gnt = 0;
        push(4'b1111, 15'h3, 64'h1234);
        step();
        chk("mid_en", send_en, 1);
        clr = 0;
        step();
        chk("rst_mid_en", send_en, 0);
        chk("rst_mid_to", send_to, 0);
        chk("rst_mid_addr", send_addr, 0);
        chk("rst_mid_word", send_word, 0);
`ifdef ICN_SENDQ_CNT_EN
        chk("rst_mid_cnt", sent_cnt, 0);
`endif
        clr = 1;
        send_gnt = 1;
        step();
        chk("rst_no_replay", send_en, 0);

        for (int blk = 0; blk < 20; blk++) begin
            int gp;
            gp = $urandom_range(0, 3);
            for (int c = 0; c < 200; c++) begin
                wr_en    = ($urandom % 3) != 0;
                wr_to    = 4'($urandom);
                if (q.size() == D && wr_to == 0) wr_to = 4'b0001;
                wr_addr  = 15'($urandom);
                wr_word  = {$urandom, $urandom};
                send_gnt = ($urandom % 4) < gp;
                flush    = ($urandom % 40) == 0;
                clr      = ($urandom % 250) != 0;
                step();
            end
        end
        wr_en = 0; flush = 0; clr = 1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
